// File: rtl/gb_load_pkg.sv
// Shared types and default image layout for the Green Beret ROM download path.
// The address-boundary constants also size the MAIN/VIDEO ROMs.
package gb_load_pkg;

   localparam int          GB_ADDR_W    = 18;
   localparam logic [17:0] GB_TOTAL_LEN = 18'h20220;
   localparam logic [17:0] GB_CPU_END   = 18'h0C000;
   localparam logic [17:0] GB_BG_END    = 18'h10000;
   localparam logic [17:0] GB_SPR_END   = 18'h20000;
   localparam logic [17:0] GB_CNT_MAX   = 18'h3FFFF;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_ERR    = 3'd4
   } gb_load_state_e;

   typedef enum logic [1:0] {
      RG_CPU  = 2'd0,
      RG_BG   = 2'd1,
      RG_SPR  = 2'd2,
      RG_PROM = 2'd3
   } gb_region_e;

endpackage

// File: rtl/gb_region_dec.sv
// Combinational image-address decoder: picks the ROM region (first match wins)
// and returns the address relative to that region's base.
import gb_load_pkg::*;

module gb_region_dec #(
   parameter logic [17:0] CPU_END = GB_CPU_END,
   parameter logic [17:0] BG_END  = GB_BG_END,
   parameter logic [17:0] SPR_END = GB_SPR_END
) (
   input  logic [17:0] addr,
   output logic [1:0]  region,
   output logic [17:0] rel_addr
);

   always_comb begin
      region   = RG_PROM;
      rel_addr = addr - SPR_END;
      if (addr < CPU_END) begin
         region   = RG_CPU;
         rel_addr = addr;
      end else if (addr < BG_END) begin
         region   = RG_BG;
         rel_addr = addr - CPU_END;
      end else if (addr < SPR_END) begin
         region   = RG_SPR;
         rel_addr = addr - BG_END;
      end
   end

endmodule

// File: rtl/gb_rom_loader.sv
// Green Beret ROM download sequencer: routes the byte stream to the ROM regions
// and holds the core in reset until a complete image has settled.
// Optional build macro GB_LOAD_CSUM_EN adds a csum port and a checksum gate on RUN.
//
// Handshake: a byte is taken in any cycle where the FSM is in LOAD and both
// dl_en and dl_wr are high; there is no backpressure, one byte per cycle is
// sustained, and the region pulse plus wr_addr/wr_data appear one cycle later.
import gb_load_pkg::*;

module gb_rom_loader #(
   parameter logic [17:0] TOTAL_LEN  = GB_TOTAL_LEN,
   parameter logic [17:0] CPU_END    = GB_CPU_END,
   parameter logic [17:0] BG_END     = GB_BG_END,
   parameter logic [17:0] SPR_END    = GB_SPR_END,
   parameter int          SETTLE_CYC = 16,
   parameter logic [7:0]  EXP_CSUM   = 8'h00
) (
   input  logic        clk48M,
   input  logic        reset,
   input  logic        dl_en,
   input  logic        dl_wr,
   input  logic [17:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        cpu_we,
   output logic        bg_we,
   output logic        spr_we,
   output logic        prom_we,
   output logic [17:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        core_reset,
   output logic        load_done,
   output logic        load_err,
   output logic [17:0] byte_cnt,
`ifdef GB_LOAD_CSUM_EN
   output logic [7:0]  csum,
`endif
   output logic [2:0]  dbg_state
);

   localparam logic [7:0] SETTLE_TC = 8'(SETTLE_CYC - 1);

   gb_load_state_e state, state_n;
   logic           dl_en_q;
   logic [7:0]     settle_cnt;
   logic [1:0]     dec_region;
   logic [17:0]    dec_rel;
   logic           accept, in_range, dl_rise, settle_tc, image_ok, load_entry;

   gb_region_dec #(
      .CPU_END (CPU_END),
      .BG_END  (BG_END),
      .SPR_END (SPR_END)
   ) u_dec (
      .addr     (dl_addr),
      .region   (dec_region),
      .rel_addr (dec_rel)
   );

   assign accept     = (state == ST_LOAD) && dl_en && dl_wr;
   assign in_range   = dl_addr < TOTAL_LEN;
   assign dl_rise    = dl_en && !dl_en_q;
   assign settle_tc  = settle_cnt == SETTLE_TC;
   assign load_entry = (state_n == ST_LOAD) && (state != ST_LOAD);

`ifdef GB_LOAD_CSUM_EN
   assign image_ok = (byte_cnt == TOTAL_LEN) && !load_err && (csum == EXP_CSUM);
`else
   assign image_ok = (byte_cnt == TOTAL_LEN) && !load_err;
`endif

   always_comb begin
      state_n = state;
      case (state)
         ST_BOOT:   if (dl_en) state_n = ST_LOAD;
         ST_LOAD:   if (!dl_en) state_n = ST_SETTLE;
         ST_SETTLE: begin
            // a new download always wins over the terminal-count verdict
            if (dl_rise)        state_n = ST_LOAD;
            else if (settle_tc) state_n = image_ok ? ST_RUN : ST_ERR;
         end
         ST_RUN:    if (dl_en) state_n = ST_LOAD;
         ST_ERR:    if (dl_rise) state_n = ST_LOAD;
         default:   state_n = ST_BOOT;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk48M or posedge reset) begin
      if (reset) begin
         state      <= ST_BOOT;
         dl_en_q    <= 1'b0;
         settle_cnt <= '0;
         core_reset <= 1'b1;
         load_done  <= 1'b0;
         dbg_state  <= ST_BOOT;
      end else begin
         state      <= state_n;
         dl_en_q    <= dl_en;
         settle_cnt <= ((state == ST_SETTLE) && (state_n == ST_SETTLE)) ? settle_cnt + 8'd1 : 8'd0;
         core_reset <= state_n != ST_RUN;
         load_done  <= state_n == ST_RUN;
         dbg_state  <= state_n;
      end
   end

   always_ff @(posedge clk48M or posedge reset) begin
      if (reset) begin
         cpu_we   <= 1'b0;
         bg_we    <= 1'b0;
         spr_we   <= 1'b0;
         prom_we  <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         byte_cnt <= '0;
         load_err <= 1'b0;
`ifdef GB_LOAD_CSUM_EN
         csum     <= '0;
`endif
      end else begin
         cpu_we  <= 1'b0;
         bg_we   <= 1'b0;
         spr_we  <= 1'b0;
         prom_we <= 1'b0;
         if (load_entry) begin
            byte_cnt <= '0;
            load_err <= 1'b0;
`ifdef GB_LOAD_CSUM_EN
            csum     <= '0;
`endif
         end else if (accept) begin
            if (in_range) begin
               cpu_we  <= dec_region == RG_CPU;
               bg_we   <= dec_region == RG_BG;
               spr_we  <= dec_region == RG_SPR;
               prom_we <= dec_region == RG_PROM;
               wr_addr <= dec_rel;
               wr_data <= dl_data;
               if (byte_cnt != GB_CNT_MAX) byte_cnt <= byte_cnt + 18'd1;
`ifdef GB_LOAD_CSUM_EN
               csum    <= csum + dl_data;
`endif
            end else begin
               load_err <= 1'b1;
            end
         end else if (state_n == ST_ERR) begin
            load_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gb_rom_loader.sv
// Self-checking bench for gb_rom_loader using a scaled-down image layout so
// every scenario finishes in a few thousand cycles.
module tb_gb_rom_loader;

  localparam logic [17:0] P_TOTAL  = 18'h220;
  localparam logic [17:0] P_CPU    = 18'h0C0;
  localparam logic [17:0] P_BG     = 18'h100;
  localparam logic [17:0] P_SPR    = 18'h200;
  localparam int          P_SETTLE = 16;
  localparam logic [7:0]  P_EXP    = 8'h5A;

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // clock / reset
  logic clk48M = 1'b0;
  always #5 clk48M = ~clk48M;

  logic        reset;
  logic        dl_en, dl_wr;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_we, bg_we, spr_we, prom_we;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset, load_done, load_err;
  logic [17:0] byte_cnt;
  logic [2:0]  dbg_state;
`ifdef GB_LOAD_CSUM_EN
  logic [7:0]  csum;
`endif

  gb_rom_loader #(
    .TOTAL_LEN  (P_TOTAL),
    .CPU_END    (P_CPU),
    .BG_END     (P_BG),
    .SPR_END    (P_SPR),
    .SETTLE_CYC (P_SETTLE),
    .EXP_CSUM   (P_EXP)
  ) dut (
    .clk48M     (clk48M),
    .reset      (reset),
    .dl_en      (dl_en),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .cpu_we     (cpu_we),
    .bg_we      (bg_we),
    .spr_we     (spr_we),
    .prom_we    (prom_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_cnt   (byte_cnt),
`ifdef GB_LOAD_CSUM_EN
    .csum       (csum),
`endif
    .dbg_state  (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // image to drive, scoreboard queue {we[3:0], wr_addr, wr_data}, model totals
  logic [17:0] img_addr[$];
  logic [7:0]  img_data[$];
  logic [29:0] exp_q[$];
  int          exp_cnt;
  bit          exp_oor;
  logic [7:0]  exp_sum;
  int          n_cpu, n_bg, n_spr, n_prom;
  logic [3:0]  probe_we;
  logic [17:0] probe_addr;

  task automatic begin_image();
    img_addr.delete();
    img_data.delete();
    exp_q.delete();
    exp_cnt = 0; exp_oor = 0; exp_sum = 8'h00;
    n_cpu = 0; n_bg = 0; n_spr = 0; n_prom = 0;
    probe_we = 4'h0; probe_addr = 18'h0;
  endtask

  // full or partial sequential image whose bytes sum to P_EXP when len >= 1
  task automatic build_seq(input int len);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < len; i++) begin
      img_addr.push_back(18'(i));
      img_data.push_back(8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < len - 1; i++) s = s + img_data[i];
    if (len > 0) img_data[len-1] = P_EXP - s;
  endtask

  task automatic shuffle_image();
    for (int i = img_addr.size() - 1; i > 0; i--) begin
      int j;
      logic [17:0] ta;
      logic [7:0]  td;
      j = $urandom_range(0, i);
      ta = img_addr[i]; img_addr[i] = img_addr[j]; img_addr[j] = ta;
      td = img_data[i]; img_data[i] = img_data[j]; img_data[j] = td;
    end
  endtask

  task automatic start_load();
    dl_en = 1'b1; dl_wr = 1'b0;
    @(posedge clk48M); #1;
  endtask

  // drive the image back-to-back and score every cycle's write port
  task automatic load_bytes();
    for (int i = 0; i < img_addr.size(); i++) begin
      logic [17:0] a;
      logic [29:0] ew;
      logic [3:0]  ow;
      a = img_addr[i];
      if (a >= P_TOTAL) begin
        exp_oor = 1'b1;
        exp_q.push_back(30'h0);
      end else begin
        exp_cnt++;
        exp_sum = exp_sum + img_data[i];
        if (a < P_CPU)      exp_q.push_back({4'b1000, a,         img_data[i]});
        else if (a < P_BG)  exp_q.push_back({4'b0100, a - P_CPU, img_data[i]});
        else if (a < P_SPR) exp_q.push_back({4'b0010, a - P_BG,  img_data[i]});
        else                exp_q.push_back({4'b0001, a - P_SPR, img_data[i]});
      end
      dl_wr = 1'b1; dl_addr = a; dl_data = img_data[i];
      @(posedge clk48M); #1;
      dl_wr = 1'b0;
      ew = exp_q.pop_front();
      ow = {cpu_we, bg_we, spr_we, prom_we};
      checks++;
      if (ow !== ew[29:26] || (ew[29:26] != 4'h0 && {wr_addr, wr_data} !== ew[25:0])
          || byte_cnt !== 18'(exp_cnt)) begin
        failures++;
        $display("FAIL write[%0d] addr=%05h: we=%b wr_addr=%05h wr_data=%02h cnt=%05h, want we=%b wr_addr=%05h wr_data=%02h cnt=%05h",
                 i, a, ow, wr_addr, wr_data, byte_cnt, ew[29:26], ew[25:8], ew[7:0], 18'(exp_cnt));
      end
      n_cpu += int'(cpu_we); n_bg += int'(bg_we); n_spr += int'(spr_we); n_prom += int'(prom_we);
      if (a == 18'h105) begin probe_we = ow; probe_addr = wr_addr; end
    end
  endtask

  // drop dl_en (optionally with a strobe in the same cycle) and score the verdict
  task automatic finish_load(input bit strobe_on_fall, output int fall_n);
    bit good;
    good = (exp_cnt == int'(P_TOTAL)) && !exp_oor;
`ifdef GB_LOAD_CSUM_EN
    good = good && (exp_sum == P_EXP);
`endif
    dl_en = 1'b0; dl_wr = strobe_on_fall; dl_addr = 18'h010; dl_data = 8'hA5;
    @(posedge clk48M); #1;
    dl_wr = 1'b0;
    if (strobe_on_fall) begin
      checks++;
      if ({cpu_we, bg_we, spr_we, prom_we} !== 4'h0 || byte_cnt !== 18'(exp_cnt)) begin
        failures++;
        $display("FAIL fall_strobe: we=%b cnt=%05h, want we=0000 cnt=%05h",
                 {cpu_we, bg_we, spr_we, prom_we}, byte_cnt, 18'(exp_cnt));
      end
    end
    fall_n = core_reset ? -1 : 1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk48M); #1;
      if (fall_n < 0 && !core_reset) fall_n = n;
    end
    checks++;
    if (fall_n != (good ? P_SETTLE + 1 : -1)) begin
      failures++;
      $display("FAIL release_time: core_reset fell at cycle %0d, want %0d (-1 = never)",
               fall_n, good ? P_SETTLE + 1 : -1);
    end
    checks++;
    if ({core_reset, load_done, load_err, dbg_state} !== {!good, good, !good, good ? S_RUN : S_ERR}
        || byte_cnt !== 18'(exp_cnt)) begin
      failures++;
      $display("FAIL verdict: rst=%b done=%b err=%b st=%0d cnt=%05h, want rst=%b done=%b err=%b st=%0d cnt=%05h",
               core_reset, load_done, load_err, dbg_state, byte_cnt,
               !good, good, !good, good ? S_RUN : S_ERR, 18'(exp_cnt));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dl_en = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    repeat (3) @(posedge clk48M);
    #1 reset = 1'b0;
    @(posedge clk48M); #1;
    checks++;
    if ({core_reset, load_done, load_err, cpu_we, bg_we, spr_we, prom_we} !== 7'b1000000
        || byte_cnt !== 18'h0 || wr_addr !== 18'h0 || wr_data !== 8'h0 || dbg_state !== S_BOOT) begin
      failures++;
      $display("FAIL reset_values: rst=%b done=%b err=%b we=%b cnt=%05h addr=%05h data=%02h st=%0d, want 1 0 0 0000 0 0 0 %0d",
               core_reset, load_done, load_err, {cpu_we, bg_we, spr_we, prom_we},
               byte_cnt, wr_addr, wr_data, dbg_state, S_BOOT);
    end
  endtask

  task automatic test_full_image();
    int f;
    begin_image();
    build_seq(int'(P_TOTAL));
    start_load();
    load_bytes();
    finish_load(1'b1, f);
    checks++;
    if (n_cpu != 'hC0 || n_bg != 'h40 || n_spr != 'h100 || n_prom != 'h20) begin
      failures++;
      $display("FAIL region_counts: cpu=%0h bg=%0h spr=%0h prom=%0h, want c0 40 100 20",
               n_cpu, n_bg, n_spr, n_prom);
    end
    checks++;
    if (probe_we !== 4'b0010 || probe_addr !== 18'h5) begin
      failures++;
      $display("FAIL spr_probe: we=%b wr_addr=%05h, want 0010 00005", probe_we, probe_addr);
    end
    checks++;
    if (f != 17 || load_done !== 1'b1) begin
      failures++;
      $display("FAIL full_run: fall=%0d done=%b, want 17 1", f, load_done);
    end
  endtask

  task automatic test_redownload();
    int f;
    begin_image();
    build_seq(int'(P_TOTAL));
    shuffle_image();
    start_load();
    checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL redownload_entry: rst=%b done=%b, want 1 0", core_reset, load_done);
    end
    load_bytes();
    finish_load(1'b0, f);
    checks++;
    if (dbg_state !== S_RUN || core_reset !== 1'b0) begin
      failures++;
      $display("FAIL redownload_run: st=%0d rst=%b, want %0d 0", dbg_state, core_reset, S_RUN);
    end
  endtask

  task automatic test_short_image();
    int f;
    begin_image();
    build_seq('h200);
    start_load();
    load_bytes();
    finish_load(1'b0, f);
    checks++;
    if (dbg_state !== S_ERR || load_err !== 1'b1 || core_reset !== 1'b1 || byte_cnt !== 18'h200) begin
      failures++;
      $display("FAIL short_err: st=%0d err=%b rst=%b cnt=%05h, want %0d 1 1 00200",
               dbg_state, load_err, core_reset, byte_cnt, S_ERR);
    end
  endtask

  task automatic test_out_of_range();
    int f;
    begin_image();
    build_seq(int'(P_TOTAL));
    shuffle_image();
    img_addr.insert($urandom_range(0, img_addr.size()), 18'h30000);
    img_data.insert(img_addr.size() - 1, 8'h77);
    for (int k = 0; k < 3; k++) begin
      int p;
      p = $urandom_range(0, img_addr.size());
      img_addr.insert(p, 18'($urandom_range(int'(P_TOTAL), 'h3FFFF)));
      img_data.insert(p, 8'($urandom_range(0, 255)));
    end
    start_load();
    load_bytes();
    finish_load(1'b0, f);
    checks++;
    if (dbg_state !== S_ERR || load_err !== 1'b1 || byte_cnt !== 18'h220) begin
      failures++;
      $display("FAIL oor_err: st=%0d err=%b cnt=%05h, want %0d 1 00220",
               dbg_state, load_err, byte_cnt, S_ERR);
    end
  endtask

  task automatic test_duplicate();
    int f;
    int p;
    begin_image();
    build_seq(int'(P_TOTAL));
    p = $urandom_range(0, int'(P_TOTAL) - 1);
    img_addr.push_back(img_addr[p]);
    img_data.push_back(8'h00);
    start_load();
    load_bytes();
    finish_load(1'b0, f);
    checks++;
    if (dbg_state !== S_ERR || byte_cnt !== 18'h221) begin
      failures++;
      $display("FAIL dup_err: st=%0d cnt=%05h, want %0d 00221", dbg_state, byte_cnt, S_ERR);
    end
  endtask

  task automatic test_reset_mid_load();
    begin_image();
    build_seq(100);
    start_load();
    load_bytes();
    dl_wr = 1'b1; dl_addr = 18'd100; dl_data = 8'h3C;
    #2 reset = 1'b1;
    @(posedge clk48M); #1;
    checks++;
    if ({cpu_we, bg_we, spr_we, prom_we} !== 4'h0 || byte_cnt !== 18'h0 || core_reset !== 1'b1
        || dbg_state !== S_BOOT || wr_addr !== 18'h0 || wr_data !== 8'h0) begin
      failures++;
      $display("FAIL mid_reset: we=%b cnt=%05h rst=%b st=%0d addr=%05h data=%02h, want 0000 0 1 %0d 0 0",
               {cpu_we, bg_we, spr_we, prom_we}, byte_cnt, core_reset, dbg_state, wr_addr, wr_data, S_BOOT);
    end
    dl_wr = 1'b0; dl_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk48M);
    #1;
    checks++;
    if (dbg_state !== S_BOOT || core_reset !== 1'b1 || {cpu_we, bg_we, spr_we, prom_we} !== 4'h0) begin
      failures++;
      $display("FAIL post_reset_boot: st=%0d rst=%b we=%b, want %0d 1 0000",
               dbg_state, core_reset, {cpu_we, bg_we, spr_we, prom_we}, S_BOOT);
    end
  endtask

  task automatic test_checksum();
    int f;
    int p;
    logic [7:0] saved_data[$];
    logic [17:0] saved_addr[$];
    begin_image();
    build_seq(int'(P_TOTAL));
    shuffle_image();
    saved_addr = img_addr;
    saved_data = img_data;
    start_load();
    load_bytes();
    finish_load(1'b0, f);
`ifdef GB_LOAD_CSUM_EN
    checks++;
    if (csum !== 8'h5A || dbg_state !== S_RUN) begin
      failures++;
      $display("FAIL csum_good: csum=%02h st=%0d, want 5a %0d", csum, dbg_state, S_RUN);
    end
`endif
    begin_image();
    img_addr = saved_addr;
    img_data = saved_data;
    p = $urandom_range(0, int'(P_TOTAL) - 1);
    img_data[p] = img_data[p] + 8'd1;
    start_load();
    load_bytes();
    finish_load(1'b0, f);
`ifdef GB_LOAD_CSUM_EN
    checks++;
    if (csum !== 8'h5B || dbg_state !== S_ERR || core_reset !== 1'b1) begin
      failures++;
      $display("FAIL csum_bad: csum=%02h st=%0d rst=%b, want 5b %0d 1", csum, dbg_state, core_reset, S_ERR);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_redownload();
    test_short_image();
    test_out_of_range();
    test_duplicate();
    test_full_image();
    test_reset_mid_load();
    test_full_image();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
